// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, issues a fixed-latency memory read and decodes IR fields.
// Optional alignment trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        instr_valid,
  output logic        busy,
  output logic        align_fault
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, VALID, FAULT} fetchState_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, VALID} fetchState_t;
`endif

  fetchState_t   state;
  logic [31:0]   pcReg;
  logic [31:0]   irReg;
  logic [31:0]   pendPc;
  logic          pendValid;
  logic [CW-1:0] waitCnt;
  logic          memRdReg;
  logic          validReg;
  logic          busyReg;
  logic [31:0]   startPc;

  // Address the upcoming fetch will use: a same-cycle redirect takes effect first.
  assign startPc = pc_load ? pc_next : pcReg;

`ifdef FETCH_ALIGN_CHECK_EN
  logic faultReg;
  assign align_fault = faultReg;
  assign mem_addr    = pcReg;
`else
  assign align_fault = 1'b0;
  assign mem_addr    = {pcReg[31:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pcReg     <= RESET_PC;
      irReg     <= '0;
      pendPc    <= '0;
      pendValid <= 1'b0;
      waitCnt   <= '0;
      memRdReg  <= 1'b0;
      validReg  <= 1'b0;
      busyReg   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      faultReg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, VALID: begin
          if (pc_load) pcReg <= pc_next;
          if (fetch_start) begin
            validReg  <= 1'b0;
            pendValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (startPc[1:0] != 2'b00) begin
              state    <= FAULT;
              faultReg <= 1'b1;
            end else begin
              state    <= ADDR;
              memRdReg <= 1'b1;
              busyReg  <= 1'b1;
            end
`else
            state    <= ADDR;
            memRdReg <= 1'b1;
            busyReg  <= 1'b1;
`endif
          end
        end
        ADDR: begin
          waitCnt <= CW'(MEM_LAT - 1);
          state   <= WAIT;
          if (pc_load) begin
            pendPc    <= pc_next;
            pendValid <= 1'b1;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state    <= LATCH;
            memRdReg <= 1'b0;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
          if (pc_load) begin
            pendPc    <= pc_next;
            pendValid <= 1'b1;
          end
        end
        LATCH: begin
          irReg <= mem_rdata;
          // Newest redirect wins over an older pending one, both win over sequential +4.
          if (pc_load)        pcReg <= pc_next;
          else if (pendValid) pcReg <= pendPc;
          else                pcReg <= pcReg + 32'd4;
          pendValid <= 1'b0;
          busyReg   <= 1'b0;
          validReg  <= 1'b1;
          state     <= VALID;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FAULT: begin
          if (pc_load) begin
            pcReg    <= pc_next;
            faultReg <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd      = memRdReg;
  assign busy        = busyReg;
  assign instr_valid = validReg;
  assign pc          = pcReg;
  assign pc_plus4    = pcReg + 32'd4;

  assign opcode = irReg[31:26];
  assign rs     = irReg[25:21];
  assign rt     = irReg[20:16];
  assign rd     = irReg[15:11];
  assign funct  = irReg[5:0];
  assign imm16  = irReg[15:0];
  assign jaddr  = irReg[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: unit A uses MEM_LAT=1, unit B uses MEM_LAT=3.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the alignment trap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchStartA, pcLoadA, fetchStartB, pcLoadB;
  logic [31:0] pcNext, memRdata;

  logic        memRdA, validA, busyA, faultA;
  logic [31:0] memAddrA, pcA, pcPlus4A;
  logic [5:0]  opcodeA, functA;
  logic [4:0]  rsA, rtA, rdA;
  logic [15:0] imm16A;
  logic [25:0] jaddrA;

  logic        memRdB, validB, busyB, faultB;
  logic [31:0] memAddrB, pcB, pcPlus4B;
  logic [5:0]  opcodeB, functB;
  logic [4:0]  rsB, rtB, rdB;
  logic [15:0] imm16B;
  logic [25:0] jaddrB;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(1)) dutA (
    .clk(clk), .reset(reset), .fetch_start(fetchStartA), .pc_load(pcLoadA), .pc_next(pcNext),
    .mem_rd(memRdA), .mem_addr(memAddrA), .mem_rdata(memRdata), .pc(pcA), .pc_plus4(pcPlus4A),
    .opcode(opcodeA), .rs(rsA), .rt(rtA), .rd(rdA), .funct(functA), .imm16(imm16A),
    .jaddr(jaddrA), .instr_valid(validA), .busy(busyA), .align_fault(faultA)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(3)) dutB (
    .clk(clk), .reset(reset), .fetch_start(fetchStartB), .pc_load(pcLoadB), .pc_next(pcNext),
    .mem_rd(memRdB), .mem_addr(memAddrB), .mem_rdata(memRdata), .pc(pcB), .pc_plus4(pcPlus4B),
    .opcode(opcodeB), .rs(rsB), .rt(rtB), .rd(rdB), .funct(functB), .imm16(imm16B),
    .jaddr(jaddrB), .instr_valid(validB), .busy(busyB), .align_fault(faultB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fetchStartA = 1'b0; pcLoadA = 1'b0; fetchStartB = 1'b0; pcLoadB = 1'b0;
    pcNext = 32'h0; memRdata = 32'h0128_5020;
    step; step;
    checkVal("rst_memrd", 32'(memRdA), 32'd0);
    checkVal("rst_pc", pcA, 32'h0);
    checkVal("rst_valid", 32'(validA), 32'd0);
    checkVal("rst_busy", 32'(busyA), 32'd0);
    checkVal("rst_fault", 32'(faultA), 32'd0);
    checkVal("rst_jaddr", 32'(jaddrA), 32'h0);
    reset = 1'b0;

    // 1: basic fetch, MEM_LAT=1
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t1_addr_rd", 32'(memRdA), 32'd1);
    checkVal("t1_addr_ma", memAddrA, 32'h0);
    checkVal("t1_addr_busy", 32'(busyA), 32'd1);
    step;
    checkVal("t1_wait_rd", 32'(memRdA), 32'd1);
    step;
    checkVal("t1_latch_rd", 32'(memRdA), 32'd0);
    checkVal("t1_latch_busy", 32'(busyA), 32'd1);
    checkVal("t1_latch_valid", 32'(validA), 32'd0);
    step;
    checkVal("t1_valid", 32'(validA), 32'd1);
    checkVal("t1_busy", 32'(busyA), 32'd0);
    checkVal("t1_opcode", 32'(opcodeA), 32'd0);
    checkVal("t1_funct", 32'(functA), 32'h20);
    checkVal("t1_rs", 32'(rsA), 32'd9);
    checkVal("t1_rt", 32'(rtA), 32'd8);
    checkVal("t1_rd", 32'(rdA), 32'd10);
    checkVal("t1_imm16", 32'(imm16A), 32'h5020);
    checkVal("t1_jaddr", 32'(jaddrA), 32'h128_5020);
    checkVal("t1_pc", pcA, 32'h4);

    // 2: MEM_LAT=3, then back-to-back fetches from VALID
    fetchStartB = 1'b1; step; fetchStartB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("t2_rd_c%0d", i), 32'(memRdB), 32'd1);
      checkVal($sformatf("t2_nv_c%0d", i), 32'(validB), 32'd0);
      step;
    end
    checkVal("t2_latch_rd", 32'(memRdB), 32'd0);
    checkVal("t2_latch_valid", 32'(validB), 32'd0);
    step;
    checkVal("t2_valid", 32'(validB), 32'd1);
    checkVal("t2_pc", pcB, 32'h4);
    fetchStartB = 1'b1; step; fetchStartB = 1'b0;
    checkVal("t2_ma2", memAddrB, 32'h4);
    repeat (5) step;
    checkVal("t2_pc2", pcB, 32'h8);
    fetchStartB = 1'b1; step; fetchStartB = 1'b0;
    checkVal("t2_ma3", memAddrB, 32'h8);
    repeat (5) step;
    checkVal("t2_pc3", pcB, 32'hC);

    // 3: redirect captured during WAIT, then redirect in LATCH itself
    memRdata = 32'hFFFF_FFFF;
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t3_ma", memAddrA, 32'h4);
    step;
    pcLoadA = 1'b1; pcNext = 32'h40; step; pcLoadA = 1'b0;
    checkVal("t3_ma_inflight", memAddrA, 32'h4);
    checkVal("t3_pc_inflight", pcA, 32'h4);
    step;
    checkVal("t3_pc_redir", pcA, 32'h40);
    checkVal("t3_opcode", 32'(opcodeA), 32'h3F);
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t3_ma_new", memAddrA, 32'h40);
    checkVal("t3_rd_new", 32'(memRdA), 32'd1);
    repeat (3) step;
    checkVal("t3_pc_seq", pcA, 32'h44);
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    step; step;
    pcLoadA = 1'b1; pcNext = 32'h100; step; pcLoadA = 1'b0;
    checkVal("t3_pc_latchload", pcA, 32'h100);

    // 4: PC wrap
    pcLoadA = 1'b1; pcNext = 32'hFFFF_FFFC; step; pcLoadA = 1'b0;
    checkVal("t4_pc", pcA, 32'hFFFF_FFFC);
    checkVal("t4_plus4", pcPlus4A, 32'h0);
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t4_ma", memAddrA, 32'hFFFF_FFFC);
    checkVal("t4_plus4_addr", pcPlus4A, 32'h0);
    repeat (3) step;
    checkVal("t4_pc_wrap", pcA, 32'h0);
    checkVal("t4_valid", 32'(validA), 32'd1);

    // 5: reset in WAIT aborts the fetch
    pcLoadA = 1'b1; pcNext = 32'h200; step; pcLoadA = 1'b0;
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    step;
    checkVal("t5_wait_rd", 32'(memRdA), 32'd1);
    reset = 1'b1; step; reset = 1'b0;
    checkVal("t5_rd", 32'(memRdA), 32'd0);
    checkVal("t5_pc", pcA, 32'h0);
    checkVal("t5_valid", 32'(validA), 32'd0);
    checkVal("t5_busy", 32'(busyA), 32'd0);
    checkVal("t5_opcode", 32'(opcodeA), 32'd0);
    step;

    // 6: misaligned PC
    pcLoadA = 1'b1; pcNext = 32'h6; step; pcLoadA = 1'b0;
    checkVal("t6_pc", pcA, 32'h6);
`ifdef FETCH_ALIGN_CHECK_EN
    fetchStartA = 1'b1; step;
    checkVal("t6_fault", 32'(faultA), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("t6_nord_c%0d", i), 32'(memRdA), 32'd0);
      step;
    end
    fetchStartA = 1'b0;
    checkVal("t6_fault_held", 32'(faultA), 32'd1);
    pcLoadA = 1'b1; pcNext = 32'h8; step; pcLoadA = 1'b0;
    checkVal("t6_fault_clr", 32'(faultA), 32'd0);
    checkVal("t6_pc8", pcA, 32'h8);
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t6_rd", 32'(memRdA), 32'd1);
    checkVal("t6_ma", memAddrA, 32'h8);
    repeat (3) step;
    checkVal("t6_valid", 32'(validA), 32'd1);
    checkVal("t6_pc_next", pcA, 32'hC);
`else
    fetchStartA = 1'b1; step; fetchStartA = 1'b0;
    checkVal("t6_rd", 32'(memRdA), 32'd1);
    checkVal("t6_ma_masked", memAddrA, 32'h4);
    checkVal("t6_fault", 32'(faultA), 32'd0);
    repeat (3) step;
    checkVal("t6_pc_low_kept", pcA, 32'hA);
    checkVal("t6_valid", 32'(validA), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
